// File: rtl/mips_mc_pkg.sv
// -----------------------------------------------------------------------------
// mips_mc_pkg
// Shared definitions for the second-generation multi-cycle MIPS control unit:
//   - opcode and Funct field constants
//   - ALU_Control codes and datapath mux-select codes
//   - ALU operation classes handed to the ALU decoder
//   - controller state enum
//   - decode_target(): DECODE-state dispatch on the opcode
// -----------------------------------------------------------------------------
package mips_mc_pkg;

    // Opcodes (instruction [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // Funct field (instruction [5:0]) for R-type
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_JR  = 6'h08;

    // ALU_Control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Mux-select codes
    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_DATA   = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic SRCA_PC = 1'b0;
    localparam logic SRCA_A  = 1'b1;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic EXT_SIGN = 1'b0;
    localparam logic EXT_ZERO = 1'b1;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    // ALU operation class chosen by the controller, refined by the decoder
    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'd0,
        ALUOP_SUB   = 3'd1,
        ALUOP_AND   = 3'd2,
        ALUOP_OR    = 3'd3,
        ALUOP_FUNCT = 3'd4
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC    = 4'd6,
        S_ALU_WB  = 4'd7,
        S_IEXEC   = 4'd8,
        S_IWB     = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12,
        S_JR      = 4'd13,
        S_TRAP    = 4'd14
    } state_t;

    // Successor of DECODE. An R-type whose Funct the ALU decoder does not
    // recognise is treated exactly like an unknown opcode.
    function automatic state_t decode_target(input logic [5:0] op,
                                             input logic [5:0] funct,
                                             input logic       funct_legal);
        state_t nxt;
        case (op)
            OP_LW, OP_SW:             nxt = S_MEM_ADR;
            OP_RTYPE: begin
                if (!funct_legal)       nxt = S_TRAP;
                else if (funct == FN_JR) nxt = S_JR;
                else                    nxt = S_EXEC;
            end
            OP_BEQ, OP_BNE:           nxt = S_BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI: nxt = S_IEXEC;
            OP_J:                     nxt = S_JUMP;
            OP_JAL:                   nxt = S_JAL;
            default:                  nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_mc_control_v2_if.sv
// -----------------------------------------------------------------------------
// mips_mc_control_v2_if
// Control/datapath bundle for the multi-cycle MIPS controller.
//   Decode inputs : Op, Funct, Zero, Mem_Ready      (datapath -> control)
//   Strobes/selects: Mem_Req .. PC_Src, Instr_Done,
//                    Trap, Retired                  (control -> datapath)
// Modports: master = control unit, slave = datapath / memory side.
// Handshake: Mem_Req is held high for every cycle of a memory state; the
// access completes on the first cycle in which Mem_Ready is sampled high
// while Mem_Req is high. Mem_Ready outside a memory state has no effect.
// -----------------------------------------------------------------------------
interface mips_mc_control_v2_if #(
    parameter int RETIRE_W   = 16,
    parameter int ALU_CTRL_W = 3
);
    logic [5:0]            Op;
    logic [5:0]            Funct;
    logic                  Zero;
    logic                  Mem_Ready;

    logic                  Mem_Req;
    logic                  PC_En;
    logic                  I_or_D;
    logic                  Mem_Write;
    logic                  IR_Write;
    logic [1:0]            Reg_Dst;
    logic [1:0]            Mem_to_Reg;
    logic                  Reg_Write;
    logic                  ALU_Src_A;
    logic [1:0]            ALU_Src_B;
    logic                  Ext_Sel;
    logic [ALU_CTRL_W-1:0] ALU_Control;
    logic [1:0]            PC_Src;
    logic                  Instr_Done;
    logic                  Trap;
    logic [RETIRE_W-1:0]   Retired;

    modport master (
        input  Op, Funct, Zero, Mem_Ready,
        output Mem_Req, PC_En, I_or_D, Mem_Write, IR_Write, Reg_Dst,
               Mem_to_Reg, Reg_Write, ALU_Src_A, ALU_Src_B, Ext_Sel,
               ALU_Control, PC_Src, Instr_Done, Trap, Retired
    );

    modport slave (
        output Op, Funct, Zero, Mem_Ready,
        input  Mem_Req, PC_En, I_or_D, Mem_Write, IR_Write, Reg_Dst,
               Mem_to_Reg, Reg_Write, ALU_Src_A, ALU_Src_B, Ext_Sel,
               ALU_Control, PC_Src, Instr_Done, Trap, Retired
    );
endinterface

// File: rtl/mips_mc_alu_decoder.sv
// -----------------------------------------------------------------------------
// mips_mc_alu_decoder
// Purely combinational ALU-control decode.
//   funct       in  Funct field of the instruction
//   alu_op      in  operation class requested by the controller
//   alu_control out ALU_Control code (Funct table used for ALUOP_FUNCT)
//   legal       out 1 when funct names a supported R-type operation
//                   (add, sub, and, or, slt, jr); independent of alu_op so
//                   the controller can use it for DECODE dispatch.
// -----------------------------------------------------------------------------
module mips_mc_alu_decoder
    import mips_mc_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic [5:0]            funct,
    input  alu_op_t               alu_op,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  legal
);
    logic [2:0] fn_code;
    logic [2:0] code;

    always_comb begin
        fn_code = ALU_ADD;
        legal   = 1'b1;
        case (funct)
            FN_ADD:  fn_code = ALU_ADD;
            FN_SUB:  fn_code = ALU_SUB;
            FN_AND:  fn_code = ALU_AND;
            FN_OR:   fn_code = ALU_OR;
            FN_SLT:  fn_code = ALU_SLT;
            FN_JR:   fn_code = ALU_ADD;
            default: legal   = 1'b0;
        endcase
    end

    always_comb begin
        code = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:   code = ALU_ADD;
            ALUOP_SUB:   code = ALU_SUB;
            ALUOP_AND:   code = ALU_AND;
            ALUOP_OR:    code = ALU_OR;
            ALUOP_FUNCT: code = fn_code;
            default:     code = ALU_ADD;
        endcase
    end

    assign alu_control = ALU_CTRL_W'(code);
endmodule

// File: rtl/mips_mc_control_v2.sv
// -----------------------------------------------------------------------------
// mips_mc_control_v2
// Multi-cycle MIPS control unit with memory wait states, illegal-opcode trap
// and retired-instruction counter.
//   clk       in  system clock
//   reset     in  asynchronous active-low reset
//   bus       master side of mips_mc_control_v2_if (decode fields in,
//             datapath strobes / selects, Trap and Retired out)
//   state_dbg out current controller state
// Outputs are decoded from the current state (Moore). The only input-dependent
// outputs are IR_Write/PC_En in FETCH and Instr_Done in MEM_WR (gated by the
// effective Mem_Ready) and PC_En in BRANCH (Zero). While reset is low every
// strobe and select is forced to 0.
// -----------------------------------------------------------------------------
module mips_mc_control_v2
    import mips_mc_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int RETIRE_W    = 16,
    parameter int ALU_CTRL_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_mc_control_v2_if.master  bus,
    output state_t                state_dbg
);
    state_t                state;
    state_t                state_next;
    logic                  trap_q;
    logic [RETIRE_W-1:0]   retired_q;
    logic                  mem_rdy;

    alu_op_t               alu_op;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  funct_legal;

    logic       mem_req_c, pc_en_c, i_or_d_c, mem_write_c, ir_write_c;
    logic [1:0] reg_dst_c, mem_to_reg_c, alu_src_b_c, pc_src_c;
    logic       reg_write_c, alu_src_a_c, ext_sel_c, done_c;

    // With wait states disabled every memory state completes in one cycle.
    assign mem_rdy = MEM_WAIT_EN ? bus.Mem_Ready : 1'b1;

    mips_mc_alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_dec (
        .funct       (bus.Funct),
        .alu_op      (alu_op),
        .alu_control (alu_control),
        .legal       (funct_legal)
    );

    // ALU operation class per state
    always_comb begin
        alu_op = ALUOP_ADD;
        case (state)
            S_EXEC:   alu_op = ALUOP_FUNCT;
            S_BRANCH: alu_op = ALUOP_SUB;
            S_IEXEC: begin
                if (bus.Op == OP_ANDI)     alu_op = ALUOP_AND;
                else if (bus.Op == OP_ORI) alu_op = ALUOP_OR;
                else                       alu_op = ALUOP_ADD;
            end
            default:  alu_op = ALUOP_ADD;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:   if (mem_rdy) state_next = S_DECODE;
            S_DECODE:  state_next = decode_target(bus.Op, bus.Funct, funct_legal);
            S_MEM_ADR: state_next = (bus.Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (mem_rdy) state_next = S_MEM_WB;
            S_MEM_WR:  if (mem_rdy) state_next = S_FETCH;
            S_EXEC:    state_next = S_ALU_WB;
            S_IEXEC:   state_next = S_IWB;
            S_MEM_WB, S_ALU_WB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                       state_next = S_FETCH;
            S_TRAP:    state_next = S_TRAP;
            default:   state_next = S_FETCH;
        endcase
    end

    // State, sticky trap flag and retired counter. Trap rises together with
    // entry into TRAP and only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            trap_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state <= state_next;
            if (state_next == S_TRAP) trap_q <= 1'b1;
            if (done_c) retired_q <= retired_q + 1'b1;
        end
    end

    // Per-state strobe and select decode
    always_comb begin
        mem_req_c    = 1'b0;
        pc_en_c      = 1'b0;
        i_or_d_c     = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_dst_c    = REG_DST_RT;
        mem_to_reg_c = M2R_ALUOUT;
        reg_write_c  = 1'b0;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_B;
        ext_sel_c    = EXT_SIGN;
        pc_src_c     = PCSRC_ALU;
        done_c       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                // IR and PC load only on the cycle the fetch completes
                ir_write_c  = mem_rdy;
                pc_en_c     = mem_rdy;
            end
            S_DECODE: alu_src_b_c = SRCB_IMM_SH2;
            S_MEM_ADR: begin
                alu_src_a_c = SRCA_A;
                alu_src_b_c = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_req_c = 1'b1;
                i_or_d_c  = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg_c = M2R_DATA;
                reg_write_c  = 1'b1;
                done_c       = 1'b1;
            end
            S_MEM_WR: begin
                // Mem_Write is held for the whole state; memory commits on
                // the Mem_Ready cycle, which is also the retire cycle.
                mem_req_c   = 1'b1;
                i_or_d_c    = 1'b1;
                mem_write_c = 1'b1;
                done_c      = mem_rdy;
            end
            S_EXEC: alu_src_a_c = SRCA_A;
            S_ALU_WB: begin
                reg_dst_c   = REG_DST_RD;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a_c = SRCA_A;
                alu_src_b_c = SRCB_IMM;
                ext_sel_c   = (bus.Op == OP_ANDI || bus.Op == OP_ORI) ? EXT_ZERO : EXT_SIGN;
            end
            S_IWB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c = SRCA_A;
                pc_src_c    = PCSRC_ALUOUT;
                pc_en_c     = (bus.Op == OP_BNE) ? ~bus.Zero : bus.Zero;
                done_c      = 1'b1;
            end
            S_JUMP: begin
                pc_src_c = PCSRC_JUMP;
                pc_en_c  = 1'b1;
                done_c   = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH; that is the link value
                pc_src_c     = PCSRC_JUMP;
                pc_en_c      = 1'b1;
                reg_dst_c    = REG_DST_RA;
                mem_to_reg_c = M2R_PC;
                reg_write_c  = 1'b1;
                done_c       = 1'b1;
            end
            S_JR: begin
                pc_src_c = PCSRC_REG;
                pc_en_c  = 1'b1;
                done_c   = 1'b1;
            end
            default: ;
        endcase
    end

    // Drive the bus; everything is held at 0 while reset is asserted.
    always_comb begin
        if (!reset) begin
            bus.Mem_Req     = 1'b0;
            bus.PC_En       = 1'b0;
            bus.I_or_D      = 1'b0;
            bus.Mem_Write   = 1'b0;
            bus.IR_Write    = 1'b0;
            bus.Reg_Dst     = 2'b00;
            bus.Mem_to_Reg  = 2'b00;
            bus.Reg_Write   = 1'b0;
            bus.ALU_Src_A   = 1'b0;
            bus.ALU_Src_B   = 2'b00;
            bus.Ext_Sel     = 1'b0;
            bus.ALU_Control = '0;
            bus.PC_Src      = 2'b00;
            bus.Instr_Done  = 1'b0;
        end else begin
            bus.Mem_Req     = mem_req_c;
            bus.PC_En       = pc_en_c;
            bus.I_or_D      = i_or_d_c;
            bus.Mem_Write   = mem_write_c;
            bus.IR_Write    = ir_write_c;
            bus.Reg_Dst     = reg_dst_c;
            bus.Mem_to_Reg  = mem_to_reg_c;
            bus.Reg_Write   = reg_write_c;
            bus.ALU_Src_A   = alu_src_a_c;
            bus.ALU_Src_B   = alu_src_b_c;
            bus.Ext_Sel     = ext_sel_c;
            bus.ALU_Control = alu_control;
            bus.PC_Src      = pc_src_c;
            bus.Instr_Done  = done_c;
        end
    end

    assign bus.Trap    = trap_q;
    assign bus.Retired = retired_q;
    assign state_dbg   = state;
endmodule

// File: tb/tb_mips_mc_control_v2.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_control_v2
// Table of per-instruction records {Op, Funct, Zero, wait counts, expected
// observation}; each record's expectation is queued when the instruction is
// driven and popped when the DUT signals Instr_Done. Hand-written sequences
// cover reset, trap, reset during a store and the no-wait-state build.
// -----------------------------------------------------------------------------
module tb_mips_mc_control_v2;
    import mips_mc_pkg::*;

    logic   clk;
    logic   reset;
    state_t state_dbg;
    state_t state_dbg_nw;

    mips_mc_control_v2_if #(.RETIRE_W(16), .ALU_CTRL_W(3)) bus ();
    mips_mc_control_v2_if #(.RETIRE_W(16), .ALU_CTRL_W(3)) bus_nw ();

    mips_mc_control_v2 #(.MEM_WAIT_EN(1'b1), .RETIRE_W(16), .ALU_CTRL_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    mips_mc_control_v2 #(.MEM_WAIT_EN(1'b0), .RETIRE_W(16), .ALU_CTRL_W(3)) dut_nw (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_nw),
        .state_dbg (state_dbg_nw)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int exp_retired = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reset released on a falling edge with Mem_Ready low, so the DUT is
    // still in FETCH at the next falling edge.
    task automatic do_reset();
        reset = 1'b0;
        bus.Mem_Ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_retired = 0;
    endtask

    // ---------------- records ----------------
    typedef struct packed {
        logic [7:0] cycles;
        logic [3:0] n_ir;
        logic [3:0] n_rw;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic [3:0] n_pc;
        logic [1:0] pc_src;
        logic [3:0] n_mw;
        logic [2:0] aluc;
        logic       ext;
        logic [3:0] n_done;
    } res_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         fwait;
        int         dwait;
        res_t       exp;
    } vec_t;

    vec_t vecs[$];
    res_t exp_q[$];

    function automatic res_t mk(int cyc, int nrw, int rdst, int m2r, int npc,
                                int pcsrc, int nmw, int aluc, int ext);
        res_t r;
        r.cycles = 8'(cyc);
        r.n_ir   = 4'd1;
        r.n_rw   = 4'(nrw);
        r.rdst   = 2'(rdst);
        r.m2r    = 2'(m2r);
        r.n_pc   = 4'(npc);
        r.pc_src = 2'(pcsrc);
        r.n_mw   = 4'(nmw);
        r.aluc   = 3'(aluc);
        r.ext    = 1'(ext);
        r.n_done = 4'd1;
        return r;
    endfunction

    task automatic add_vec(input string name, input logic [5:0] op, input logic [5:0] funct,
                           input logic zero, input int fw, input int dw, input res_t e);
        vec_t v;
        v.name  = name;
        v.op    = op;
        // Funct is a don't-care outside R-type; randomise it there
        v.funct = (op == OP_RTYPE) ? funct : 6'($urandom_range(0, 63));
        v.zero  = zero;
        v.fwait = fw;
        v.dwait = dw;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    // ---------------- driver + monitor ----------------
    // One sample per state cycle at the falling edge. Mem_Ready is set from
    // the current Mem_Req/I_or_D (a tiny memory model with programmable wait
    // counts); outside memory states it is random and must be ignored.
    task automatic run_instr(input vec_t v, output res_t o, output bit timed_out);
        res_t r;
        int   fw;
        int   dw;
        bit   seen_done;
        r  = '0;
        fw = v.fwait;
        dw = v.dwait;
        seen_done = 1'b0;
        bus.Op    = v.op;
        bus.Funct = v.funct;
        bus.Zero  = v.zero;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.Mem_Req) begin
                if (!bus.I_or_D && fw > 0) begin
                    bus.Mem_Ready = 1'b0;
                    fw--;
                end else if (bus.I_or_D && dw > 0) begin
                    bus.Mem_Ready = 1'b0;
                    dw--;
                end else begin
                    bus.Mem_Ready = 1'b1;
                end
            end else begin
                bus.Mem_Ready = 1'($urandom_range(0, 1));
            end
            #1;
            r.cycles = r.cycles + 8'd1;
            if (bus.IR_Write) r.n_ir = r.n_ir + 4'd1;
            if (bus.Reg_Write) begin
                r.n_rw = r.n_rw + 4'd1;
                r.rdst = bus.Reg_Dst;
                r.m2r  = bus.Mem_to_Reg;
            end
            if (bus.PC_En && !bus.IR_Write) begin
                r.n_pc   = r.n_pc + 4'd1;
                r.pc_src = bus.PC_Src;
            end
            if (bus.Mem_Write && bus.Mem_Ready) r.n_mw = r.n_mw + 4'd1;
            if (bus.ALU_Src_A) begin
                r.aluc = bus.ALU_Control;
                r.ext  = bus.Ext_Sel;
            end
            if (bus.Instr_Done) begin
                r.n_done  = r.n_done + 4'd1;
                seen_done = 1'b1;
                break;
            end
        end
        o = r;
        timed_out = !seen_done;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        res_t obs;
        res_t e;
        bit   to;
        int   n;
        int   bad;

        reset          = 1'b1;
        bus.Op         = 6'h00;
        bus.Funct      = 6'h00;
        bus.Zero       = 1'b0;
        bus.Mem_Ready  = 1'b0;
        bus_nw.Op        = OP_LW;
        bus_nw.Funct     = 6'h00;
        bus_nw.Zero      = 1'b0;
        bus_nw.Mem_Ready = 1'b0;

        //                 cyc rw rd m2r pc psrc mw aluc    ext
        add_vec("add",    OP_RTYPE, FN_ADD, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, ALU_ADD, 0));
        add_vec("sub",    OP_RTYPE, FN_SUB, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, ALU_SUB, 0));
        add_vec("and",    OP_RTYPE, FN_AND, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, ALU_AND, 0));
        add_vec("or",     OP_RTYPE, FN_OR,  0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, ALU_OR,  0));
        add_vec("slt",    OP_RTYPE, FN_SLT, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, ALU_SLT, 0));
        add_vec("lw",     OP_LW,    0,      0, 0, 0, mk(5, 1, 0, 1, 0, 0, 0, ALU_ADD, 0));
        add_vec("lw_w3",  OP_LW,    0,      0, 0, 3, mk(8, 1, 0, 1, 0, 0, 0, ALU_ADD, 0));
        add_vec("lw_f2",  OP_LW,    0,      0, 2, 0, mk(7, 1, 0, 1, 0, 0, 0, ALU_ADD, 0));
        add_vec("sw",     OP_SW,    0,      0, 0, 0, mk(4, 0, 0, 0, 0, 0, 1, ALU_ADD, 0));
        add_vec("sw_w2",  OP_SW,    0,      0, 0, 2, mk(6, 0, 0, 0, 0, 0, 1, ALU_ADD, 0));
        add_vec("beq_z1", OP_BEQ,   0,      1, 0, 0, mk(3, 0, 0, 0, 1, 1, 0, ALU_SUB, 0));
        add_vec("beq_z0", OP_BEQ,   0,      0, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, ALU_SUB, 0));
        add_vec("bne_z1", OP_BNE,   0,      1, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, ALU_SUB, 0));
        add_vec("bne_z0", OP_BNE,   0,      0, 0, 0, mk(3, 0, 0, 0, 1, 1, 0, ALU_SUB, 0));
        add_vec("addi",   OP_ADDI,  0,      0, 0, 0, mk(4, 1, 0, 0, 0, 0, 0, ALU_ADD, 0));
        add_vec("andi",   OP_ANDI,  0,      0, 0, 0, mk(4, 1, 0, 0, 0, 0, 0, ALU_AND, 1));
        add_vec("ori",    OP_ORI,   0,      0, 0, 0, mk(4, 1, 0, 0, 0, 0, 0, ALU_OR,  1));
        add_vec("j",      OP_J,     0,      0, 0, 0, mk(3, 0, 0, 0, 1, 2, 0, 0, 0));
        add_vec("jal",    OP_JAL,   0,      0, 0, 0, mk(3, 1, 2, 2, 1, 2, 0, 0, 0));
        add_vec("jr",     OP_RTYPE, FN_JR,  0, 0, 0, mk(3, 0, 0, 0, 1, 3, 0, 0, 0));
        add_vec("j_f1",   OP_J,     0,      0, 1, 0, mk(4, 0, 0, 0, 1, 2, 0, 0, 0));

        // ---- reset state and first fetch ----
        #2 reset = 1'b0;
        #1;
        check("rst_strobes", 32'({bus.Mem_Req, bus.PC_En, bus.IR_Write, bus.Mem_Write,
                                  bus.Reg_Write, bus.Instr_Done}), 32'd0);
        check("rst_selects", 32'({bus.I_or_D, bus.Reg_Dst, bus.Mem_to_Reg, bus.ALU_Src_A,
                                  bus.ALU_Src_B, bus.Ext_Sel, bus.ALU_Control, bus.PC_Src}), 32'd0);
        check("rst_retired", 32'(bus.Retired), 32'd0);
        check("rst_trap", 32'(bus.Trap), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(S_FETCH));
        do_reset();
        @(negedge clk);
        bus.Mem_Ready = 1'b0;
        #1;
        check("fetch_wait_req", 32'({bus.Mem_Req, bus.I_or_D}), 32'b10);
        check("fetch_wait_noload", 32'({bus.IR_Write, bus.PC_En}), 32'b00);
        @(negedge clk);
        bus.Mem_Ready = 1'b1;
        #1;
        check("fetch_rdy_load", 32'({bus.Mem_Req, bus.I_or_D, bus.IR_Write, bus.PC_En, bus.PC_Src}), 32'b1011_00);
        check("fetch_retired", 32'(bus.Retired), 32'd0);

        // ---- table ----
        do_reset();
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].exp);
            run_instr(vecs[i], obs, to);
            check({vecs[i].name, ".timeout"}, 32'(to), 32'd0);
            e = exp_q.pop_front();
            check({vecs[i].name, ".cycles"}, 32'(obs.cycles), 32'(e.cycles));
            check({vecs[i].name, ".ir_write"}, 32'(obs.n_ir), 32'(e.n_ir));
            check({vecs[i].name, ".reg_write"}, 32'({obs.n_rw, obs.rdst, obs.m2r}),
                  32'({e.n_rw, e.rdst, e.m2r}));
            check({vecs[i].name, ".pc_load"}, 32'({obs.n_pc, obs.pc_src}), 32'({e.n_pc, e.pc_src}));
            check({vecs[i].name, ".mem_write"}, 32'(obs.n_mw), 32'(e.n_mw));
            check({vecs[i].name, ".alu"}, 32'({obs.aluc, obs.ext}), 32'({e.aluc, e.ext}));
            check({vecs[i].name, ".done"}, 32'(obs.n_done), 32'(e.n_done));
            exp_retired = exp_retired + 1;
            @(posedge clk);
            #1;
            check({vecs[i].name, ".retired"}, 32'(bus.Retired), 32'(16'(exp_retired)));
            if (to) do_reset();
        end

        // ---- illegal opcode ----
        do_reset();
        bus.Op = 6'h3F;
        bus.Funct = 6'($urandom_range(0, 63));
        bus.Mem_Ready = 1'b1;
        n = 0;
        while (!bus.Trap && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("trap_set", 32'(bus.Trap), 32'd1);
        check("trap_latency", 32'(n), 32'd2);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.Mem_Ready = 1'($urandom_range(0, 1));
            bus.Op = 6'($urandom_range(0, 63));
            #1;
            if (bus.Mem_Req || bus.PC_En || bus.IR_Write || bus.Mem_Write ||
                bus.Reg_Write || bus.Instr_Done || !bus.Trap) bad++;
        end
        check("trap_quiet", 32'(bad), 32'd0);
        check("trap_retired", 32'(bus.Retired), 32'd0);
        reset = 1'b0;
        #1;
        check("trap_clear", 32'(bus.Trap), 32'd0);

        // ---- unknown R-type Funct ----
        do_reset();
        bus.Op = OP_RTYPE;
        bus.Funct = 6'h3F;
        bus.Mem_Ready = 1'b1;
        n = 0;
        while (!bus.Trap && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("trap_funct", 32'({bus.Trap, 4'(n)}), 32'({1'b1, 4'd2}));

        // ---- reset during a stalled store ----
        do_reset();
        bus.Op = OP_SW;
        bus.Funct = 6'($urandom_range(0, 63));
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (bus.Mem_Req && bus.I_or_D) begin
                bus.Mem_Ready = 1'b0;
                break;
            end
            bus.Mem_Ready = 1'b1;
        end
        check("wr_reached", 32'(n < 10), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        check("wr_hold", 32'({bus.Mem_Write, bus.Instr_Done}), 32'b10);
        #2 reset = 1'b0;
        #1;
        check("wr_abort", 32'({bus.Mem_Write, bus.Mem_Req, bus.Reg_Write, bus.Instr_Done}), 32'd0);
        check("wr_abort_state", 32'(state_dbg), 32'(S_FETCH));
        check("wr_abort_retired", 32'(bus.Retired), 32'd0);
        @(negedge clk);
        bus.Mem_Ready = 1'b0;
        reset = 1'b1;
        #1;
        check("wr_refetch", 32'({bus.Mem_Req, bus.I_or_D, bus.Mem_Write}), 32'b100);

        // ---- build without wait states: Mem_Ready held low ----
        do_reset();
        #1;
        n = 1;
        while (!bus_nw.Instr_Done && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("nw_lw_cycles", 32'(n), 32'd5);
        check("nw_lw_wb", 32'({bus_nw.Reg_Write, bus_nw.Mem_to_Reg}), 32'b1_01);
        @(posedge clk);
        #1;
        check("nw_retired", 32'(bus_nw.Retired), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop so the bench always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
